// File: rtl/mult_share_arbiter_if.sv
// Client/multiplier bundle for the shared multiplier arbiter.
// master: the client side plus multiplier core; slave: the arbiter.
interface mult_share_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = 32
);
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] op_a;
    logic [NREQ*W-1:0] op_b;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   rsp_valid;
    logic [2*W-1:0]    rsp_data;
    logic              rsp_err;
    logic              busy;
    logic              m_init;
    logic              m_rst;
    logic [W-1:0]      m_a;
    logic [W-1:0]      m_b;
    logic              m_done;
    logic [2*W-1:0]    m_pp;

    modport master (
        output req, op_a, op_b, m_done, m_pp,
        input  gnt, rsp_valid, rsp_data, rsp_err, busy, m_init, m_rst, m_a, m_b
    );

    modport slave (
        input  req, op_a, op_b, m_done, m_pp,
        output gnt, rsp_valid, rsp_data, rsp_err, busy, m_init, m_rst, m_a, m_b
    );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one sequential multiplier among NREQ clients.
// Every output is registered; the comb process computes the next value of
// every register, the seq process commits it.
module mult_share_arbiter #(
    parameter int NREQ    = 4,
    parameter int W       = 32,
    parameter int TIMEOUT = 255
) (
    input logic                clk,
    input logic                rst,
    mult_share_arbiter_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;

    state_t          state, state_n;
    logic [PW-1:0]   rr_ptr, rr_n;
    logic [PW-1:0]   owner, owner_n;
    logic [TW-1:0]   tmo_cnt, tmo_n;
    logic [NREQ-1:0] gnt_q, gnt_n;
    logic [NREQ-1:0] rv_q, rv_n;
    logic            err_q, err_n;
    logic [2*W-1:0]  data_q, data_n;
    logic [W-1:0]    ma_q, ma_n;
    logic [W-1:0]    mb_q, mb_n;
    logic            init_q, init_n;
    logic            mrst_q, mrst_n;
    logic            busy_q, busy_n;

    logic [PW-1:0]   win;
    logic [PW-1:0]   idx;
    logic            found;

    // Next-state and next-output logic, including the rotating priority search.
    always_comb begin
        state_n = state;
        rr_n    = rr_ptr;
        owner_n = owner;
        tmo_n   = tmo_cnt;
        gnt_n   = '0;
        rv_n    = '0;
        err_n   = 1'b0;
        data_n  = data_q;
        ma_n    = ma_q;
        mb_n    = mb_q;
        init_n  = 1'b0;
        mrst_n  = 1'b0;
        win     = '0;
        idx     = '0;
        found   = 1'b0;

        // First requester at or above rr_ptr, wrapping past NREQ-1.
        for (int k = 0; k < NREQ; k++) begin
            idx = PW'((int'(rr_ptr) + k) % NREQ);
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end

        case (state)
            IDLE: begin
                if (found) begin
                    gnt_n[win] = 1'b1;
                    ma_n       = bus.op_a[win*W +: W];
                    mb_n       = bus.op_b[win*W +: W];
                    owner_n    = win;
                    rr_n       = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
                    state_n    = ISSUE;
                end
            end
            ISSUE: begin
                init_n  = 1'b1;
                tmo_n   = '0;
                state_n = WAIT;
            end
            WAIT: begin
                // A done arriving on the timeout cycle still counts as success.
                if (bus.m_done) begin
                    data_n      = bus.m_pp;
                    rv_n[owner] = 1'b1;
                    state_n     = DRAIN;
                end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                    mrst_n      = 1'b1;
                    data_n      = '0;
                    rv_n[owner] = 1'b1;
                    err_n       = 1'b1;
                    state_n     = DRAIN;
                end else begin
                    tmo_n = tmo_cnt + 1'b1;
                end
            end
            DRAIN: begin
                // Hold off until done drops so it cannot complete the next job.
                if (!bus.m_done) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
    end

    // Register state and all outputs; synchronous reset drops any job in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            owner   <= '0;
            tmo_cnt <= '0;
            gnt_q   <= '0;
            rv_q    <= '0;
            err_q   <= 1'b0;
            data_q  <= '0;
            ma_q    <= '0;
            mb_q    <= '0;
            init_q  <= 1'b0;
            mrst_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_n;
            rr_ptr  <= rr_n;
            owner   <= owner_n;
            tmo_cnt <= tmo_n;
            gnt_q   <= gnt_n;
            rv_q    <= rv_n;
            err_q   <= err_n;
            data_q  <= data_n;
            ma_q    <= ma_n;
            mb_q    <= mb_n;
            init_q  <= init_n;
            mrst_q  <= mrst_n;
            busy_q  <= busy_n;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.rsp_valid = rv_q;
    assign bus.rsp_err   = err_q;
    assign bus.rsp_data  = data_q;
    assign bus.m_a       = ma_q;
    assign bus.m_b       = mb_q;
    assign bus.m_init    = init_q;
    assign bus.m_rst     = mrst_q;
    assign bus.busy      = busy_q;
endmodule
